idu_decode_stage: RTL and testbench

//  Registered RV32/RV64 I(+M, +Zicsr/system) decode stage between IFU and EXU. Accepts {pc, inst} on a

---
 rtl/idu_decode_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_idu_decode_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_decode_stage.sv
// Decode stage between IFU and EXU. Decodes the incoming instruction into the
// EXU control bundle and holds it in a 2-entry FIFO: a main register feeding the
// outputs plus a skid register. in_ready depends only on stored state, never on
// out_ready.
module idu_decode_stage #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned HAS_M   = 1,
  parameter int unsigned HAS_SYS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [4:0]      alu_ct,
  output logic [2:0]      ext_op,
  output logic            reg_wr,
  output logic            alu_a_src,
  output logic [1:0]      alu_b_src,
  output logic [2:0]      branch,
  output logic            mem_wr,
  output logic [2:0]      mem_op,
  output logic [1:0]      reg_src,
  output logic            is_trunc,
  output logic            is_sext,
  output logic            intr_en,
  output logic            illegal
);

  localparam logic RV64  = (XLEN == 64);
  localparam logic M_EN  = (HAS_M != 0);
  localparam logic SY_EN = (HAS_SYS != 0);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      alu_ct;
    logic [2:0]      ext_op;
    logic            reg_wr;
    logic            alu_a_src;
    logic [1:0]      alu_b_src;
    logic [2:0]      branch;
    logic            mem_wr;
    logic [2:0]      mem_op;
    logic [1:0]      reg_src;
    logic            is_trunc;
    logic            is_sext;
    logic            intr_en;
    logic            illegal;
  } entry_t;

  entry_t     dec;
  entry_t     m_q;
  entry_t     s_q;
  logic       m_valid;
  logic       s_valid;
  logic       legal;
  logic       is_mul;
  logic       accept;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] f6;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];
  assign f6  = in_inst[31:26];

  // Combinational decode of the incoming instruction word
  always_comb begin
    dec           = '0;
    legal         = 1'b0;
    is_mul        = 1'b0;
    dec.alu_a_src = 1'b1;
    dec.branch    = 3'b010;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        legal = 1'b1; dec.ext_op = 3'd5; dec.alu_a_src = 1'b0;
      end
      OPC_JAL: begin
        legal = 1'b1; dec.ext_op = 3'd6; dec.alu_a_src = 1'b0;
        dec.alu_b_src = 2'd2; dec.branch = 3'b110;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); dec.ext_op = 3'd2; dec.alu_a_src = 1'b0;
        dec.alu_b_src = 2'd2; dec.branch = 3'b111;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011); dec.ext_op = 3'd4;
        dec.alu_b_src = 2'd1; dec.branch = f3 & 3'b101;
      end
      OPC_LOAD: begin
        dec.ext_op = 3'd2; dec.reg_src = 2'd1; legal = 1'b1;
        case (f3)
          3'b000:  dec.mem_op = 3'b111;
          3'b001:  dec.mem_op = 3'b110;
          3'b010:  dec.mem_op = 3'b101;
          3'b011:  begin dec.mem_op = 3'b100; legal = RV64; end
          3'b100:  dec.mem_op = 3'b011;
          3'b101:  dec.mem_op = 3'b010;
          3'b110:  begin dec.mem_op = 3'b001; legal = RV64; end
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        dec.ext_op = 3'd3; dec.mem_wr = 1'b1; legal = 1'b1;
        case (f3)
          3'b000:  dec.mem_op = 3'b011;
          3'b001:  dec.mem_op = 3'b010;
          3'b010:  dec.mem_op = 3'b001;
          3'b011:  begin dec.mem_op = 3'b100; legal = RV64; end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec.ext_op = 3'd2;
        // RV64 shifts use a 6-bit shamt, so only inst[31:26] is the function field
        if (f3 == 3'b001)
          legal = RV64 ? (f6 == 6'b000000) : (f7 == F7_BASE);
        else if (f3 == 3'b101)
          legal = RV64 ? ((f6 == 6'b000000) || (f6 == 6'b010000))
                       : ((f7 == F7_BASE) || (f7 == F7_ALT));
        else
          legal = 1'b1;
      end
      OPC_OP_IMM32: begin
        dec.ext_op = 3'd2; dec.is_trunc = 1'b1; dec.is_sext = 1'b1;
        legal = RV64 && ((f3 == 3'b000) ||
                         ((f3 == 3'b001) && (f7 == F7_BASE)) ||
                         ((f3 == 3'b101) && ((f7 == F7_BASE) || (f7 == F7_ALT))));
      end
      OPC_OP: begin
        dec.ext_op = 3'd1; dec.alu_b_src = 2'd1; is_mul = (f7 == F7_MUL);
        legal = (f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                (is_mul && M_EN);
      end
      OPC_OP32: begin
        dec.ext_op = 3'd1; dec.alu_b_src = 2'd1; is_mul = (f7 == F7_MUL);
        dec.is_trunc = 1'b1; dec.is_sext = 1'b1;
        legal = RV64 && (((f7 == F7_BASE) && ((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101))) ||
                         ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                         (is_mul && M_EN && (f3 != 3'b001) && (f3 != 3'b010) && (f3 != 3'b011)));
      end
      OPC_SYSTEM: begin
        dec.ext_op = 3'd2; dec.reg_src = 2'd2; dec.alu_a_src = 1'b0;
        dec.intr_en = 1'b1; legal = SY_EN && (f3 != 3'b100);
      end
      default: legal = 1'b0;
    endcase
    dec.alu_ct = {is_mul, f7[5], f3};
    dec.reg_wr = (dec.ext_op == 3'd1) || (dec.ext_op == 3'd2) ||
                 (dec.ext_op == 3'd5) || (dec.ext_op == 3'd6);
    // Illegal entries still flow to the trap unit, but with every control cleared
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.pc   = in_pc;
    dec.inst = in_inst;
  end

  assign in_ready = ~s_valid & ~rst;
  assign accept   = in_valid & in_ready & ~flush;

  // Main/skid FIFO update; flush drops both entries and any same-cycle input
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q     <= '0;
      s_q     <= '0;
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || out_ready) begin
      if (s_valid) begin
        m_q     <= s_q;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else begin
        m_valid <= accept;
        if (accept) m_q <= dec;
      end
    end else if (accept) begin
      s_q     <= dec;
      s_valid <= 1'b1;
    end
  end

  assign out_valid = m_valid;
  assign out_pc    = m_q.pc;
  assign out_inst  = m_q.inst;
  assign alu_ct    = m_q.alu_ct;
  assign ext_op    = m_q.ext_op;
  assign reg_wr    = m_q.reg_wr;
  assign alu_a_src = m_q.alu_a_src;
  assign alu_b_src = m_q.alu_b_src;
  assign branch    = m_q.branch;
  assign mem_wr    = m_q.mem_wr;
  assign mem_op    = m_q.mem_op;
  assign reg_src   = m_q.reg_src;
  assign is_trunc  = m_q.is_trunc;
  assign is_sext   = m_q.is_sext;
  assign intr_en   = m_q.intr_en;
  assign illegal   = m_q.illegal;

endmodule

// File: tb/tb_idu_decode_stage.sv
// Directed bench for idu_decode_stage: a full-featured RV64 instance plus a
// reduced RV32 / no-M / no-SYSTEM instance sharing the same input stimulus.
module tb_idu_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;

  logic        in_ready, out_valid, reg_wr, alu_a_src, mem_wr, is_trunc, is_sext, intr_en, illegal;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [4:0]  alu_ct;
  logic [2:0]  ext_op, branch, mem_op;
  logic [1:0]  alu_b_src, reg_src;

  logic        b_in_ready, b_out_valid, b_reg_wr, b_alu_a_src, b_mem_wr, b_is_trunc, b_is_sext, b_intr_en, b_illegal;
  logic [31:0] b_out_pc;
  logic [31:0] b_out_inst;
  logic [4:0]  b_alu_ct;
  logic [2:0]  b_ext_op, b_branch, b_mem_op;
  logic [1:0]  b_alu_b_src, b_reg_src;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  idu_decode_stage #(.XLEN(64), .HAS_M(1), .HAS_SYS(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .alu_ct(alu_ct), .ext_op(ext_op), .reg_wr(reg_wr),
    .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .branch(branch), .mem_wr(mem_wr),
    .mem_op(mem_op), .reg_src(reg_src), .is_trunc(is_trunc), .is_sext(is_sext),
    .intr_en(intr_en), .illegal(illegal)
  );

  idu_decode_stage #(.XLEN(32), .HAS_M(0), .HAS_SYS(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc[31:0]), .in_inst(in_inst), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_inst(b_out_inst), .alu_ct(b_alu_ct), .ext_op(b_ext_op), .reg_wr(b_reg_wr),
    .alu_a_src(b_alu_a_src), .alu_b_src(b_alu_b_src), .branch(b_branch), .mem_wr(b_mem_wr),
    .mem_op(b_mem_op), .reg_src(b_reg_src), .is_trunc(b_is_trunc), .is_sext(b_is_sext),
    .intr_en(b_intr_en), .illegal(b_illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the main instance's decoded bundle
  task automatic check_ctl(input string tag, input logic [2:0] e_ext, input logic e_wr,
                           input logic e_a, input logic [1:0] e_b, input logic [2:0] e_br,
                           input logic e_mw, input logic [2:0] e_mop, input logic [1:0] e_rs,
                           input logic [4:0] e_ct, input logic e_ill);
    check({tag, ".valid"},  64'(out_valid), 64'd1);
    check({tag, ".ext_op"}, 64'(ext_op),    64'(e_ext));
    check({tag, ".reg_wr"}, 64'(reg_wr),    64'(e_wr));
    check({tag, ".a_src"},  64'(alu_a_src), 64'(e_a));
    check({tag, ".b_src"},  64'(alu_b_src), 64'(e_b));
    check({tag, ".branch"}, 64'(branch),    64'(e_br));
    check({tag, ".mem_wr"}, 64'(mem_wr),    64'(e_mw));
    check({tag, ".mem_op"}, 64'(mem_op),    64'(e_mop));
    check({tag, ".reg_src"},64'(reg_src),   64'(e_rs));
    check({tag, ".alu_ct"}, 64'(alu_ct),    64'(e_ct));
    check({tag, ".illegal"},64'(illegal),   64'(e_ill));
  endtask

  task automatic issue(input logic [63:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] s_inst [4] = '{32'h00012083, 32'h00110023, 32'h008000EF, 32'h00209463};
  logic [2:0]  s_mop  [4] = '{3'b101, 3'b011, 3'b000, 3'b000};
  logic        s_mw   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [2:0]  s_br   [4] = '{3'b010, 3'b010, 3'b110, 3'b001};
  logic [2:0]  s_ext  [4] = '{3'd2, 3'd3, 3'd6, 3'd4};
  logic        s_wr   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    tick(); tick();

    // Reset state
    check("rst.in_ready",  64'(in_ready),  64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_pc",    out_pc,         64'd0);
    check("rst.ext_op",    64'(ext_op),    64'd0);
    rst = 1'b0;
    #1;
    check("rst_rel.in_ready", 64'(in_ready), 64'd1);

    // addi x1,x0,5
    out_ready = 1'b1;
    issue(64'h1000, 32'h00500093);
    check_ctl("addi", 3'd2, 1'b1, 1'b1, 2'd0, 3'b010, 1'b0, 3'b000, 2'd0, 5'd0, 1'b0);
    check("addi.pc", out_pc, 64'h1000);
    tick();
    check("addi.popped", 64'(out_valid), 64'd0);

    // lw/sb/jal/bne back to back, one per cycle
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        in_valid = 1'b1;
        in_pc    = 64'h2000 + 64'(4 * i);
        in_inst  = s_inst[i];
      end else begin
        in_valid = 1'b0;
      end
      if (i > 0) begin
        check($sformatf("stream%0d.valid", i-1),  64'(out_valid), 64'd1);
        check($sformatf("stream%0d.inst", i-1),   64'(out_inst),  64'(s_inst[i-1]));
        check($sformatf("stream%0d.mem_op", i-1), 64'(mem_op),    64'(s_mop[i-1]));
        check($sformatf("stream%0d.mem_wr", i-1), 64'(mem_wr),    64'(s_mw[i-1]));
        check($sformatf("stream%0d.branch", i-1), 64'(branch),    64'(s_br[i-1]));
        check($sformatf("stream%0d.ext_op", i-1), 64'(ext_op),    64'(s_ext[i-1]));
        check($sformatf("stream%0d.reg_wr", i-1), 64'(reg_wr),    64'(s_wr[i-1]));
        check($sformatf("stream%0d.in_ready", i-1), 64'(in_ready), 64'd1);
      end
      tick();
    end
    check("stream.drained", 64'(out_valid), 64'd0);

    // Back-pressure: add, sub, xor with out_ready low for three cycles
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h3000; in_inst = 32'h002081B3;
    check("bp.a.in_ready", 64'(in_ready), 64'd1);
    tick();
    in_pc = 64'h3004; in_inst = 32'h402081B3;
    check("bp.b.in_ready", 64'(in_ready), 64'd1);
    check("bp.b.out_inst", 64'(out_inst), 64'h002081B3);
    tick();
    in_pc = 64'h3008; in_inst = 32'h0020C1B3;
    check("bp.c.in_ready", 64'(in_ready), 64'd0);
    check("bp.c.out_inst", 64'(out_inst), 64'h002081B3);
    check("bp.c.alu_ct",   64'(alu_ct),   64'd0);
    tick();
    out_ready = 1'b1;
    check("bp.d.in_ready", 64'(in_ready), 64'd0);
    check("bp.d.out_inst", 64'(out_inst), 64'h002081B3);
    check("bp.d.out_pc",   out_pc,        64'h3000);
    tick();
    check("bp.e.in_ready", 64'(in_ready), 64'd1);
    check("bp.e.out_inst", 64'(out_inst), 64'h402081B3);
    check("bp.e.alu_ct",   64'(alu_ct),   64'h08);
    tick();
    in_valid = 1'b0;
    check("bp.f.out_inst", 64'(out_inst), 64'h0020C1B3);
    check("bp.f.out_pc",   out_pc,        64'h3008);
    check("bp.f.alu_ct",   64'(alu_ct),   64'h04);
    tick();
    check("bp.g.out_valid", 64'(out_valid), 64'd0);

    // Parameter-dependent legality: main = RV64+M+SYS, dut_b = RV32, no M, no SYS
    issue(64'h4000, 32'h002081BB);
    check_ctl("addw", 3'd1, 1'b1, 1'b1, 2'd1, 3'b010, 1'b0, 3'b000, 2'd0, 5'd0, 1'b0);
    check("addw.trunc",   64'(is_trunc),  64'd1);
    check("addw.sext",    64'(is_sext),   64'd1);
    check("addw.b_valid", 64'(b_out_valid), 64'd1);
    check("addw.b_ill",   64'(b_illegal), 64'd1);
    check("addw.b_regwr", 64'(b_reg_wr),  64'd0);
    check("addw.b_ext",   64'(b_ext_op),  64'd0);
    check("addw.b_inst",  64'(b_out_inst), 64'h002081BB);

    issue(64'h4004, 32'h022081B3);
    check_ctl("mul", 3'd1, 1'b1, 1'b1, 2'd1, 3'b010, 1'b0, 3'b000, 2'd0, 5'h10, 1'b0);
    check("mul.b_ill",    64'(b_illegal), 64'd1);
    check("mul.b_alu_ct", 64'(b_alu_ct),  64'd0);

    issue(64'h4008, 32'h00000073);
    check_ctl("ecall", 3'd2, 1'b1, 1'b0, 2'd0, 3'b010, 1'b0, 3'b000, 2'd2, 5'd0, 1'b0);
    check("ecall.intr",   64'(intr_en),   64'd1);
    check("ecall.b_ill",  64'(b_illegal), 64'd1);
    check("ecall.b_intr", 64'(b_intr_en), 64'd0);

    issue(64'h400C, 32'h00013083);
    check_ctl("ld", 3'd2, 1'b1, 1'b1, 2'd0, 3'b010, 1'b0, 3'b100, 2'd1, 5'd3, 1'b0);
    check("ld.b_ill",    64'(b_illegal), 64'd1);
    check("ld.b_mem_op", 64'(b_mem_op),  64'd0);

    issue(64'h4010, 32'h0000007F);
    check_ctl("badop", 3'd0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 3'b000, 2'd0, 5'd0, 1'b1);
    tick();
    check("param.drained", 64'(out_valid), 64'd0);

    // Flush with both entries full and a same-cycle input
    out_ready = 1'b0;
    issue(64'h5000, 32'h00100093);
    issue(64'h5004, 32'h00200093);
    check("fl.full.in_ready", 64'(in_ready), 64'd0);
    check("fl.full.out_pc",   out_pc,        64'h5000);
    flush = 1'b1; in_valid = 1'b1; in_pc = 64'h5008; in_inst = 32'h00300093;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.out_valid", 64'(out_valid), 64'd0);
    check("fl.in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    tick();
    check("fl.stale1", 64'(out_valid), 64'd0);
    tick();
    check("fl.stale2", 64'(out_valid), 64'd0);

    // Reset with a valid entry on the output
    out_ready = 1'b0;
    issue(64'h6000, 32'h00012083);
    check("rm.out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("rm.out_valid0", 64'(out_valid), 64'd0);
    check("rm.out_pc",     out_pc,         64'd0);
    check("rm.out_inst",   64'(out_inst),  64'd0);
    check("rm.mem_op",     64'(mem_op),    64'd0);
    check("rm.reg_wr",     64'(reg_wr),    64'd0);
    check("rm.branch",     64'(branch),    64'd0);
    check("rm.in_ready",   64'(in_ready),  64'd0);
    rst = 1'b0;
    #1;
    check("rm.rel.in_ready", 64'(in_ready), 64'd1);
    tick();
    check("rm.rel.out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
